// File: rtl/sine_table_wr_if.sv
// Host write port of the sine table controller: load strobe plus a
// valid/ready word stream that fills the table in address order.
interface sine_table_wr_if #(
  parameter int DATA_WIDTH = 15
);
  // A word transfers on a rising clock edge where i_WriteValid and
  // o_WriteReady are both 1; the host holds i_WriteData stable while
  // i_WriteValid is 1 and may drop i_WriteValid at any time.
  logic                  i_LoadStart;
  logic                  i_WriteValid;
  logic                  o_WriteReady;
  logic [DATA_WIDTH-1:0] i_WriteData;

  modport master (
    output i_LoadStart,
    output i_WriteValid,
    output i_WriteData,
    input  o_WriteReady
  );

  modport slave (
    input  i_LoadStart,
    input  i_WriteValid,
    input  i_WriteData,
    output o_WriteReady
  );
endinterface

// File: rtl/sine_table_controller.sv
// Quarter-wave sine RAM with a load sequencer: streams a full table in,
// checksums it, and mutes pipeline reads until the table is complete.
module sine_table_controller #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 15,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  sine_table_wr_if.slave        wr,
  input  logic [ADDR_WIDTH-1:0] i_ReadAddress,
  output logic [DATA_WIDTH-1:0] o_ReadData,
  output logic                  o_TableReady,
  output logic                  o_Mute,
  output logic [15:0]           o_Checksum,
  output logic [ADDR_WIDTH-1:0] o_WriteAddress,
  output logic [1:0]            o_DebugState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           sum_q, sum_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, table_ready_q, mute_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_en;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr.i_LoadStart) begin
          state_d = LOAD;
          addr_d  = '0;
          sum_d   = '0;
        end
      end
      LOAD: begin
        // A restart wins over a same-cycle handshake, which is dropped.
        if (wr.i_LoadStart) begin
          addr_d = '0;
          sum_d  = '0;
        end else if (wr.i_WriteValid && ready_q) begin
          wr_en  = 1'b1;
          sum_d  = sum_q + 16'(wr.i_WriteData);
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (addr_q == {ADDR_WIDTH{1'b1}}) state_d = RUN;
        end
      end
      RUN: begin
        if (wr.i_LoadStart) begin
          state_d = DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = LOAD;
          addr_d  = '0;
          sum_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with
  // the state register while having no combinational input path.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      sum_q         <= '0;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      table_ready_q <= 1'b0;
      mute_q        <= 1'b1;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      ready_q       <= (state_d == LOAD);
      table_ready_q <= (state_d == RUN);
      mute_q        <= (state_d != RUN);
      rd_data_q     <= (state_q == RUN) ? mem[i_ReadAddress] : '0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[addr_q] <= wr.i_WriteData;
  end

  assign wr.o_WriteReady = ready_q;
  assign o_ReadData      = rd_data_q;
  assign o_TableReady    = table_ready_q;
  assign o_Mute          = mute_q;
  assign o_Checksum      = sum_q;
  assign o_WriteAddress  = addr_q;
  assign o_DebugState    = state_q;

endmodule

// File: tb/tb_sine_table_controller.sv
// Directed bench for sine_table_controller: read results go through an
// expected queue checked by a monitor; status outputs are checked inline.
module tb_sine_table_controller;

  localparam int AW = 14;
  localparam int DW = 15;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          table_ready;
  logic          mute;
  logic [15:0]   checksum;
  logic [AW-1:0] wr_addr;
  logic [1:0]    dbg_state;

  sine_table_wr_if #(.DATA_WIDTH(DW)) wr ();

  sine_table_controller #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DRAIN_CYCLES(4)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .wr            (wr.slave),
    .i_ReadAddress (rd_addr),
    .o_ReadData    (rd_data),
    .o_TableReady  (table_ready),
    .o_Mute        (mute),
    .o_Checksum    (checksum),
    .o_WriteAddress(wr_addr),
    .o_DebugState  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic          rd_issue = 1'b0;
  logic          rd_due   = 1'b0;

  always @(posedge clk) rd_due <= rd_issue;

  always @(negedge clk) begin
    if (rd_due) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_underflow: got 0x%0h with no expected entry", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL read_data: got 0x%0h expected 0x%0h", rd_data, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_addr  = a;
    rd_issue = 1'b1;
    exp_q.push_back(e);
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic pulse_start();
    wr.i_LoadStart = 1'b1;
    tick();
    wr.i_LoadStart = 1'b0;
  endtask

  // Streams words data=index+1; gap is the percent chance of an idle cycle.
  task automatic load_words(input int n, input int gap);
    int budget;
    logic hs;
    budget = 0;
    for (int i = 0; i < n; i++) begin
      hs = 1'b0;
      while (!hs) begin
        budget++;
        if (budget > 40000) begin
          n_vec++;
          n_err++;
          $display("FAIL load_timeout: word %0d not accepted", i);
          wr.i_WriteValid = 1'b0;
          return;
        end
        if ($urandom_range(0, 99) < gap) begin
          wr.i_WriteValid = 1'b0;
          tick();
        end else begin
          wr.i_WriteValid = 1'b1;
          wr.i_WriteData  = DW'(i + 1);
          hs = wr.o_WriteReady;
          tick();
        end
      end
    end
    wr.i_WriteValid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (wr.o_WriteReady !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check(name, {31'd0, wr.o_WriteReady}, 32'd1);
  endtask

  task automatic check_run_loaded(input string tag);
    check({tag, "_table_ready"}, {31'd0, table_ready}, 32'd1);
    check({tag, "_mute"}, {31'd0, mute}, 32'd0);
    check({tag, "_checksum"}, {16'd0, checksum}, 32'h2000);
    check({tag, "_wr_addr"}, {18'd0, wr_addr}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_RUN});
    check({tag, "_wr_ready"}, {31'd0, wr.o_WriteReady}, 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    rd_addr         = '0;
    wr.i_LoadStart  = 1'b0;
    wr.i_WriteValid = 1'b0;
    wr.i_WriteData  = '0;
    #23;
    check("rst_wr_ready", {31'd0, wr.o_WriteReady}, 32'd0);
    check("rst_table_ready", {31'd0, table_ready}, 32'd0);
    check("rst_mute", {31'd0, mute}, 32'd1);
    check("rst_checksum", {16'd0, checksum}, 32'd0);
    check("rst_wr_addr", {18'd0, wr_addr}, 32'd0);
    check("rst_rd_data", {17'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    issue_read(14'h0000, 15'h0000);

    // 1: full back-to-back load
    pulse_start();
    check("load_state", {30'd0, dbg_state}, {30'd0, ST_LOAD});
    check("load_ready", {31'd0, wr.o_WriteReady}, 32'd1);
    load_words(16384, 0);
    check_run_loaded("s1");

    // 2: reads in RUN
    issue_read(14'h0000, 15'h0001);
    issue_read(14'h3FFF, 15'h4000);
    issue_read(14'h1234, 15'h1235);
    issue_read(14'h2000, 15'h2001);

    // 3: reload through DRAIN; a start strobe inside DRAIN is ignored
    pulse_start();
    check("drain_mute", {31'd0, mute}, 32'd1);
    check("drain_table_ready", {31'd0, table_ready}, 32'd0);
    check("drain_state", {30'd0, dbg_state}, {30'd0, ST_DRAIN});
    pulse_start();
    issue_read(14'h0000, 15'h0000);
    tick();
    check("drain_ready_low", {31'd0, wr.o_WriteReady}, 32'd0);
    tick();
    check("drain_ready_high", {31'd0, wr.o_WriteReady}, 32'd1);
    check("drain_checksum", {16'd0, checksum}, 32'd0);
    check("drain_wr_addr", {18'd0, wr_addr}, 32'd0);
    issue_read(14'h0000, 15'h0000);
    issue_read(14'h3FFF, 15'h0000);

    // 4: restart in LOAD discards the same-cycle word
    load_words(100, 0);
    check("s4_wr_addr_100", {18'd0, wr_addr}, 32'd100);
    check("s4_checksum_100", {16'd0, checksum}, 32'h13BA);
    wr.i_LoadStart  = 1'b1;
    wr.i_WriteValid = 1'b1;
    wr.i_WriteData  = 15'h7FFF;
    tick();
    wr.i_LoadStart  = 1'b0;
    wr.i_WriteValid = 1'b0;
    check("s4_restart_addr", {18'd0, wr_addr}, 32'd0);
    check("s4_restart_checksum", {16'd0, checksum}, 32'd0);
    check("s4_restart_ready", {31'd0, wr.o_WriteReady}, 32'd1);
    load_words(16384, 0);
    check_run_loaded("s4");
    issue_read(14'h0064, 15'h0065);

    // 5: full load with idle gaps
    pulse_start();
    wait_ready("s5_drain_done");
    load_words(16384, 30);
    check_run_loaded("s5");
    issue_read(14'h0000, 15'h0001);
    issue_read(14'h3FFF, 15'h4000);
    issue_read(14'h0ABC, 15'h0ABD);

    // 6: async reset in the middle of a load
    pulse_start();
    wait_ready("s6_drain_done");
    load_words(5000, 0);
    check("s6_wr_addr", {18'd0, wr_addr}, 32'd5000);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_wr_ready", {31'd0, wr.o_WriteReady}, 32'd0);
    check("s6_rst_mute", {31'd0, mute}, 32'd1);
    check("s6_rst_checksum", {16'd0, checksum}, 32'd0);
    check("s6_rst_wr_addr", {18'd0, wr_addr}, 32'd0);
    check("s6_rst_table_ready", {31'd0, table_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("s6_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("s6_table_ready", {31'd0, table_ready}, 32'd0);
    issue_read(14'h0000, 15'h0000);
    tick();
    tick();

    // final report
    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
